// File: rtl/tick_bcd_display.sv
// -----------------------------------------------------------------------------
// tick_bcd_display
//
// Consumes the divided square wave from the clock divider (tick_in, already
// synchronous to clk). Its rising edges drive two things:
//   * a prescaled 4-digit BCD up/down counter (one count step every
//     TICKS_PER_COUNT rising edges while run is high);
//   * the scan of a 4-digit multiplexed, active-low seven-segment display
//     (one digit per rising edge, regardless of run or clear).
//
// Parameters:
//   TICKS_PER_COUNT - tick_in rising edges per count step, 1..1023
//   PRE_W           - prescaler width, 2**PRE_W >= TICKS_PER_COUNT
//
// Ports:
//   clk        in   system clock (same clock as the divider)
//   reset      in   synchronous, active-high reset
//   tick_in    in   divided square wave, synchronous to clk
//   run        in   1 = prescaler advances on ticks, 0 = prescaler/count hold
//   clear      in   synchronous clear of count and prescaler
//   up_down    in   1 = count up, 0 = count down
//   count_bcd  out  {thousands, hundreds, tens, ones} BCD digits
//   wrap       out  one-cycle pulse on 9999->0000 (up) or 0000->9999 (down)
//   an         out  digit enables, active-low, an[0] = ones digit
//   seg        out  segments {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module tick_bcd_display #(
    parameter int unsigned TICKS_PER_COUNT = 1000,
    parameter int unsigned PRE_W           = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_in,
    input  logic        run,
    input  logic        clear,
    input  logic        up_down,
    output logic [15:0] count_bcd,
    output logic        wrap,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    // Terminal prescaler value; reaching it on a tick produces a count step.
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_COUNT - 1);

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Decimal increment of four BCD digits. Bit 16 is the carry out of the
    // thousands digit, i.e. the 9999 -> 0000 rollover.
    function automatic logic [16:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (v[4*i +: 4] >= 4'd9) begin
                    // 9 rolls to 0 and carries; out-of-range digits are
                    // forced back to 0 as well
                    r[4*i +: 4] = 4'd0;
                    c           = 1'b1;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c           = 1'b0;
                end
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return {c, r};
    endfunction

    // Decimal decrement of four BCD digits. Bit 16 is the borrow out of the
    // thousands digit, i.e. the 0000 -> 9999 rollunder.
    function automatic logic [16:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                    b           = 1'b1;
                end else if (v[4*i +: 4] > 4'd9) begin
                    // out-of-range digit snaps to 9 without borrowing
                    r[4*i +: 4] = 4'd9;
                    b           = 1'b0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b           = 1'b0;
                end
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return {b, r};
    endfunction

    // Active-low seven-segment pattern {g,f,e,d,c,b,a} for one BCD digit.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic             tick_q;
    logic [PRE_W-1:0] pre_q,   pre_d;
    logic             step_q,  step_d;
    logic [15:0]      count_q, count_d;
    logic             wrap_q,  wrap_d;
    logic [1:0]       idx_q,   idx_d;
    logic [3:0]       an_q,    an_d;
    logic [6:0]       seg_q,   seg_d;

    logic             tick_s;
    logic [16:0]      inc_s;
    logic [16:0]      dec_s;
    logic [3:0]       digit_s;

    // Next-state logic for edge detect, prescaler, counter and display scan.
    always_comb begin
        tick_s  = tick_in & ~tick_q;
        inc_s   = bcd_inc(count_q);
        dec_s   = bcd_dec(count_q);

        pre_d   = pre_q;
        step_d  = 1'b0;
        count_d = count_q;
        wrap_d  = 1'b0;
        idx_d   = idx_q;
        an_d    = 4'b1111;
        digit_s = 4'd0;

        if (clear) begin
            // clear wins over an in-flight step; the step is dropped and
            // no wrap is reported
            pre_d   = {PRE_W{1'b0}};
            step_d  = 1'b0;
            count_d = 16'h0000;
            wrap_d  = 1'b0;
        end else begin
            // The step registered on the previous tick lands now; direction
            // is sampled here so up_down changes apply to the next step.
            if (step_q) begin
                if (up_down) begin
                    count_d = inc_s[15:0];
                    wrap_d  = inc_s[16];
                end else begin
                    count_d = dec_s[15:0];
                    wrap_d  = dec_s[16];
                end
            end else begin
                count_d = count_q;
                wrap_d  = 1'b0;
            end

            if (tick_s && run) begin
                if (pre_q == PRE_LAST) begin
                    pre_d  = {PRE_W{1'b0}};
                    step_d = 1'b1;
                end else begin
                    pre_d  = pre_q + PRE_W'(1);
                    step_d = 1'b0;
                end
            end else begin
                pre_d  = pre_q;
                step_d = 1'b0;
            end
        end

        // Scan position follows every tick, independent of run and clear.
        if (tick_s) begin
            idx_d = idx_q + 2'd1;
        end else begin
            idx_d = idx_q;
        end

        // Display is driven from the current index and count; the
        // registered copy lags them by one cycle.
        case (idx_q)
            2'd0:    begin an_d = 4'b1110; digit_s = count_q[3:0];   end
            2'd1:    begin an_d = 4'b1101; digit_s = count_q[7:4];   end
            2'd2:    begin an_d = 4'b1011; digit_s = count_q[11:8];  end
            2'd3:    begin an_d = 4'b0111; digit_s = count_q[15:12]; end
            default: begin an_d = 4'b1110; digit_s = count_q[3:0];   end
        endcase
        seg_d = seg_decode(digit_s);
    end

    // State registers with synchronous reset; the edge register tracks
    // tick_in even in reset so a high tick_in at release is not an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q  <= tick_in;
            pre_q   <= {PRE_W{1'b0}};
            step_q  <= 1'b0;
            count_q <= 16'h0000;
            wrap_q  <= 1'b0;
            idx_q   <= 2'd0;
            an_q    <= 4'b1111;
            seg_q   <= 7'b1111111;
        end else begin
            tick_q  <= tick_in;
            pre_q   <= pre_d;
            step_q  <= step_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign count_bcd = count_q;
    assign wrap      = wrap_q;
    assign an        = an_q;
    assign seg       = seg_q;

endmodule

// File: tb/tb_tick_bcd_display.sv
module tb_tick_bcd_display;

    localparam int T = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset   = 1'b1;
    logic        tick_in = 1'b1;
    logic        run     = 1'b1;
    logic        clear   = 1'b0;
    logic        up_down = 1'b1;
    logic [15:0] count_bcd;
    logic        wrap;
    logic [3:0]  an;
    logic [6:0]  seg;

    tick_bcd_display #(.TICKS_PER_COUNT(T), .PRE_W(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick_in   (tick_in),
        .run       (run),
        .clear     (clear),
        .up_down   (up_down),
        .count_bcd (count_bcd),
        .wrap      (wrap),
        .an        (an),
        .seg       (seg)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: count kept as a plain integer 0..9999
    int         m_cnt   = 0;
    int         m_pre   = 0;
    int         m_idx   = 0;
    int         m_edges = 0;
    bit         m_pend  = 1'b0;
    bit         m_prev  = 1'b0;
    bit         m_wrap  = 1'b0;
    logic [3:0] m_an    = 4'b1111;
    logic [6:0] m_seg   = 7'b1111111;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};
    int p10 [4] = '{1, 10, 100, 1000};

    bit wave_en    = 1'b1;
    int wave_ph    = 0;
    int wraps_seen = 0;

    typedef struct {
        bit          run;
        bit          up;
        int          edges;
        logic [15:0] exp_cnt;
        int          exp_wraps;
    } row_t;
    row_t rows [10];

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit         edge_s;
        int         digit;
        logic [3:0] one;
        one = 4'b0001;
        if (reset) begin
            m_prev = tick_in;
            m_pre  = 0;
            m_pend = 1'b0;
            m_cnt  = 0;
            m_wrap = 1'b0;
            m_idx  = 0;
            m_an   = 4'b1111;
            m_seg  = 7'b1111111;
        end else begin
            edge_s = tick_in && !m_prev;
            digit  = (m_cnt / p10[m_idx]) % 10;
            m_an   = ~(one << m_idx);
            m_seg  = seg_tab[digit];
            if (clear) begin
                m_cnt  = 0;
                m_wrap = 1'b0;
            end else if (m_pend) begin
                if (up_down) begin
                    m_wrap = (m_cnt == 9999);
                    m_cnt  = (m_cnt + 1) % 10000;
                end else begin
                    m_wrap = (m_cnt == 0);
                    m_cnt  = (m_cnt + 9999) % 10000;
                end
            end else begin
                m_wrap = 1'b0;
            end
            if (clear) begin
                m_pend = 1'b0;
                m_pre  = 0;
            end else if (edge_s && run) begin
                m_pend = (m_pre == T - 1);
                m_pre  = (m_pre + 1) % T;
            end else begin
                m_pend = 1'b0;
            end
            if (edge_s) begin
                m_idx = (m_idx + 1) % 4;
                m_edges++;
            end
            m_prev = tick_in;
        end
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge
    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        if (wrap === 1'b1) wraps_seen++;
        check("cyc_count", 32'(count_bcd), 32'(to_bcd(m_cnt)));
        check("cyc_wrap",  32'(wrap),      32'(m_wrap));
        check("cyc_an",    32'(an),        32'(m_an));
        check("cyc_seg",   32'(seg),       32'(m_seg));
        if (wave_en) begin
            wave_ph = (wave_ph + 1) % 10;
            tick_in = (wave_ph < 5);
        end
    endtask

    task automatic run_edges(input int n);
        int start;
        int budget;
        start  = m_edges;
        budget = 12 * n + 20;
        while ((m_edges - start) < n && budget > 0) begin
            cycle();
            budget--;
        end
        check("edge_budget", 32'(m_edges - start), 32'(n));
    endtask

    initial begin
        rows[0] = '{1'b1, 1'b1, 4,  16'h0001, 0};
        rows[1] = '{1'b1, 1'b1, 8,  16'h0003, 0};
        rows[2] = '{1'b1, 1'b0, 12, 16'h0000, 0};
        rows[3] = '{1'b1, 1'b0, 4,  16'h9999, 1};
        rows[4] = '{1'b1, 1'b0, 4,  16'h9998, 0};
        rows[5] = '{1'b1, 1'b1, 8,  16'h0000, 1};
        rows[6] = '{1'b0, 1'b1, 20, 16'h0000, 0};
        rows[7] = '{1'b1, 1'b1, 40, 16'h0010, 0};
        rows[8] = '{1'b1, 1'b0, 4,  16'h0009, 0};
        rows[9] = '{1'b1, 1'b1, 4,  16'h0010, 0};

        // Reset with tick_in high, then release while it is still high
        wave_en = 1'b1; wave_ph = 0; tick_in = 1'b1;
        reset = 1'b1; run = 1'b1; clear = 1'b0; up_down = 1'b1;
        cycle();
        cycle();
        check("reset_count", 32'(count_bcd), 32'h0000);
        check("reset_an",    32'(an),        32'hF);
        check("reset_seg",   32'(seg),       32'h7F);
        reset = 1'b0;
        cycle();
        check("first_an",  32'(an),  32'(4'b1110));
        check("first_seg", 32'(seg), 32'(7'b1000000));

        // Table of phases: controls, edge count, expected count and wraps
        for (int i = 0; i < 10; i++) begin
            run        = rows[i].run;
            up_down    = rows[i].up;
            wraps_seen = 0;
            run_edges(rows[i].edges);
            cycle();
            cycle();
            check($sformatf("row%0d_count", i), 32'(count_bcd), 32'(rows[i].exp_cnt));
            check($sformatf("row%0d_wraps", i), 32'(wraps_seen), 32'(rows[i].exp_wraps));
            if (i == 0) begin
                check("row0_an",  32'(an),  32'(4'b1110));
                check("row0_seg", 32'(seg), 32'(7'b1111001));
            end
        end

        // Clear coinciding with a wrapping down step
        clear = 1'b1; cycle(); clear = 1'b0;
        check("clr_to_zero", 32'(count_bcd), 32'h0000);
        up_down = 1'b0; wraps_seen = 0;
        run_edges(4);
        clear = 1'b1; cycle(); clear = 1'b0;
        check("clr_step_count", 32'(count_bcd), 32'h0000);
        check("clr_step_wrap",  32'(wrap),      32'h0);
        cycle();
        check("clr_step_wraps", 32'(wraps_seen), 32'h0);

        // Clear resets a half-way prescaler
        up_down = 1'b1;
        run_edges(2);
        clear = 1'b1; cycle(); clear = 1'b0;
        run_edges(3); cycle(); cycle();
        check("clr_pre_hold", 32'(count_bcd), 32'h0000);
        run_edges(1); cycle(); cycle();
        check("clr_pre_step", 32'(count_bcd), 32'h0001);

        // Reset mid-count (0123, prescaler at 2) while tick_in is high
        run_edges(4 * 122); cycle(); cycle();
        check("pre_reset_count", 32'(count_bcd), 32'h0123);
        run_edges(2);
        reset = 1'b1; cycle(); reset = 1'b0;
        check("mid_reset_count", 32'(count_bcd), 32'h0000);
        check("mid_reset_an",    32'(an),        32'hF);
        check("mid_reset_seg",   32'(seg),       32'h7F);
        cycle();
        check("post_reset_an",  32'(an),  32'(4'b1110));
        check("post_reset_seg", 32'(seg), 32'(7'b1000000));
        run_edges(4); cycle(); cycle();
        check("post_reset_step", 32'(count_bcd), 32'h0001);

        // Randomized traffic against the model
        wave_en = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 2) == 0) tick_in = ~tick_in;
            run   = ($urandom_range(0, 7) != 0);
            clear = ($urandom_range(0, 63) == 0);
            reset = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 31) == 0) up_down = ~up_down;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tick_bcd_display.md
Name: tick_bcd_display

Overview:
- Downstream consumer of the clock divider's output. Takes the divided square wave (tick_in), which is generated from the same clk and so is already synchronous to it.
- Rising-edge detects tick_in and uses the edges for two jobs:
  - a prescaled 4-digit BCD up/down counter;
  - scanning a 4-digit multiplexed, active-low seven-segment display.
- Typical use: divider set to 1 kHz feeds this block. Result is a 1 Hz counter with a 250 Hz per-digit refresh.

Parameters:
- TICKS_PER_COUNT, 1000: tick_in rising edges per counter step. Legal range 1..1023.
- PRE_W, 10: prescaler width. Must satisfy 2^PRE_W >= TICKS_PER_COUNT.

Ports:
- clk  input  1  system clock. Same clock that drives the clock divider.
- reset  input  1  synchronous, active-high reset.
- tick_in  input  1  divided clock from the clock divider. Square wave, synchronous to clk.
- run  input  1  1 = prescaler advances on ticks; 0 = prescaler and count hold.
- clear  input  1  synchronous clear of count and prescaler.
- up_down  input  1  1 = count up, 0 = count down.
- count_bcd  output  16  {thousands, hundreds, tens, ones}, each a BCD digit 0..9.
- wrap  output  1  one-cycle pulse on 9999->0000 (up) or 0000->9999 (down).
- an  output  4  digit enables, active-low; an[0] = ones digit.
- seg  output  7  {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset (synchronous, active-high, checked every clk edge while high):
  - count_bcd=0, prescaler=0, scan index=0, wrap=0, an=4'b1111, seg=7'b1111111;
  - edge register loads tick_in, so no spurious edge on reset release.
- Edge detect:
  - tick_q <= tick_in every cycle;
  - tick = tick_in & ~tick_q. This is a 1-cycle pulse, internal only.
- Prescaler:
  - on tick with run=1: if pre==TICKS_PER_COUNT-1 then pre<=0 and step=1; else pre<=pre+1;
  - run=0: pre holds and no steps occur;
  - TICKS_PER_COUNT=1: every tick with run=1 steps.
- Count step, in the cycle after the tick pulse:
  - up: ones+1 with decimal carry through all digits;
  - down: ones-1 with decimal borrow;
  - digits never leave 0..9.
- Wrap:
  - up from 9999 -> 0000 with wrap=1;
  - down from 0000 -> 9999 with wrap=1;
  - wrap is 0 on all other cycles.
- Clear:
  - priority: reset > clear > step;
  - clear=1 sets count_bcd=0 and pre=0 the next cycle;
  - an in-flight step that coincides with clear is discarded, and wrap stays 0;
  - clear does not affect the scan index.
- up_down changes take effect on the next step. There is no glitch on count_bcd.
- Scan:
  - 2-bit index increments (mod 4) on every tick, independent of run and clear;
  - an and seg are registered every cycle from the current index and count, giving 1-cycle latency;
  - idx0 -> an=1110, ones; idx1 -> 1101, tens; idx2 -> 1011, hundreds; idx3 -> 0111, thousands.
- Seg decode, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001;
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000;
  - any other value = 1111111 (defensive only; not reachable).
- Exactly one an bit is low at any time after the first post-reset cycle.
- Reset mid-operation, including mid-tick-high: all state returns to reset values next cycle. A tick_in still high after release produces no edge until it falls and rises again.

Test Plan:
- Common bench setup: TICKS_PER_COUNT=4; tick_in = square wave, 5 clk high / 5 clk low.
- Reset release with tick_in high, run=1, up_down=1:
  - no count for the first partial tick;
  - after 4 rising edges, count_bcd=16'h0001;
  - an=1110 and seg=1111001 when idx=0.
- Up wrap: preload via 39996 edges, or a bench-forced 9999:
  - next step gives count_bcd=16'h0000;
  - wrap high for exactly 1 cycle.
- Down from 0000 (up_down=0), 4 edges:
  - count_bcd=16'h9999, wrap=1 for 1 cycle;
  - 4 more edges give 16'h9998.
- Clear and run:
  - clear asserted in the same cycle as a step: count_bcd=0, wrap=0, pre=0;
  - run=0 for 20 edges: count frozen while an keeps rotating 1110->1101->1011->0111->1110.
- Reset mid-count (count=16'h0123, pre=2):
  - 1 cycle of reset gives count 0, an=1111, seg=1111111;
  - the first display after reset is an=1110, seg=1000000.
